// File: rtl/phy_tx_lane_arbiter_pkg.sv
// phy_tx_lane_arbiter_pkg: shared types, defaults and the round-robin pick helper
//   state_t  link states RESET/INIT/IDLE/ACTIVE
//   LANES    number of input lanes, LANE_W lane-id width
//   COM_DEF / IDLE_DEF default framing and filler symbols
package phy_tx_lane_arbiter_pkg;
   typedef enum logic [1:0] {ST_RESET, ST_INIT, ST_IDLE, ST_ACTIVE} state_t;
   localparam int LANES = 4;
   localparam int LANE_W = 2;
   localparam logic [7:0] COM_DEF = 8'hBC;
   localparam logic [7:0] IDLE_DEF = 8'h7C;
   // Scan offsets high to low so the nearest requester at or above ptr wins last.
   function automatic logic [LANE_W-1:0] rr_pick(input logic [LANES-1:0] req, input logic [LANE_W-1:0] ptr);
      logic [LANE_W-1:0] idx;
      rr_pick = ptr;
      for (int i = LANES - 1; i >= 0; i--) begin
         idx = ptr + LANE_W'(i);
         if (req[idx]) rr_pick = idx;
      end
   endfunction
endpackage

// File: rtl/phy_tx_lane_arbiter_if.sv
// phy_tx_lane_arbiter_if: lane inputs, link enable and merged output stream
//   master: drives enable, valid0..3, data_in0..3, out_ready; sees full0..3 and the output stream
//   slave : the arbiter side of the same signals
interface phy_tx_lane_arbiter_if #(parameter int DATA_W = 8);
   logic enable;
   logic valid0, valid1, valid2, valid3;
   logic [DATA_W-1:0] data_in0, data_in1, data_in2, data_in3;
   logic full0, full1, full2, full3;
   logic out_ready;
   logic [DATA_W-1:0] data_out;
   logic valid_out;
   logic [1:0] lane_out;
   logic active;
   logic idle_out;
   logic overflow;
   modport master (output enable, valid0, valid1, valid2, valid3, data_in0, data_in1, data_in2, data_in3, out_ready,
                   input full0, full1, full2, full3, data_out, valid_out, lane_out, active, idle_out, overflow);
   modport slave (input enable, valid0, valid1, valid2, valid3, data_in0, data_in1, data_in2, data_in3, out_ready,
                  output full0, full1, full2, full3, data_out, valid_out, lane_out, active, idle_out, overflow);
endinterface

// File: rtl/phy_tx_lane_fifo.sv
// phy_tx_lane_fifo: per-lane byte FIFO
//   clk_f/reset  clock, async active-high reset (clears contents)
//   push/din     write; ignored when full
//   pop/head     read; head is the oldest entry, pop ignored when empty
//   full/empty   combinational from the entry count
module phy_tx_lane_fifo #(
   parameter int DATA_W = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk_f,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic              full,
   output logic              empty,
   output logic [DATA_W-1:0] head
);
   localparam int AW = $clog2(FIFO_DEPTH);
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] count;
   logic do_push, do_pop;
   assign full = count == (AW + 1)'(FIFO_DEPTH);
   assign empty = count == '0;
   assign head = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop = pop && !empty;
   always_ff @(posedge clk_f or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         if (do_push) mem[wr_ptr] <= din;
         wr_ptr <= wr_ptr + AW'(do_push);
         rd_ptr <= rd_ptr + AW'(do_pop);
         count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
      end
   end
endmodule

// File: rtl/phy_tx_lane_arbiter.sv
// phy_tx_lane_arbiter: link bring-up FSM and round-robin merge of four lane FIFOs
//   clk_f  clock, rising edge
//   reset  async active-high, clears everything including FIFO contents
//   bus    slave side of phy_tx_lane_arbiter_if (lane inputs, full flags, registered output stream)
module phy_tx_lane_arbiter
   import phy_tx_lane_arbiter_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int INIT_CYCLES = 4,
   parameter logic [DATA_W-1:0] COM_SYM = COM_DEF,
   parameter logic [DATA_W-1:0] IDLE_SYM = IDLE_DEF
) (
   input logic clk_f,
   input logic reset,
   phy_tx_lane_arbiter_if.slave bus
);
   localparam int CW = $clog2(INIT_CYCLES + 1);
   state_t state, state_nx;
   logic [CW-1:0] init_cnt, cnt_nx;
   logic [LANE_W-1:0] rr_ptr, rr_nx, grant;
   logic [LANES-1:0] valid_v, full_v, empty_v, push_v, pop_v;
   logic [DATA_W-1:0] din_v [LANES];
   logic [DATA_W-1:0] head_v [LANES];
   logic [DATA_W-1:0] data_q, data_nx;
   logic [LANE_W-1:0] lane_q, lane_nx;
   logic valid_q, valid_nx, active_q, active_nx, idle_q, idle_nx, ovf_q;
   logic load, accept, any_req, last_com;
   assign valid_v = {bus.valid3, bus.valid2, bus.valid1, bus.valid0};
   assign din_v[0] = bus.data_in0;
   assign din_v[1] = bus.data_in1;
   assign din_v[2] = bus.data_in2;
   assign din_v[3] = bus.data_in3;
   assign {bus.full3, bus.full2, bus.full1, bus.full0} = full_v;
   // full is sampled before this edge's pop, so a full lane rejects even while draining
   assign push_v = valid_v & ~full_v;
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      phy_tx_lane_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
         .clk_f(clk_f), .reset(reset), .push(push_v[i]), .pop(pop_v[i]), .din(din_v[i]),
         .full(full_v[i]), .empty(empty_v[i]), .head(head_v[i])
      );
   end
   assign load = !valid_q || bus.out_ready;
   assign accept = valid_q && bus.out_ready;
   assign any_req = |(~empty_v);
   assign last_com = init_cnt == CW'(INIT_CYCLES - 1);
   assign grant = rr_pick(~empty_v, rr_ptr);
   always_ff @(posedge clk_f or posedge reset) begin
      if (reset) state <= ST_RESET;
      else state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      if (!bus.enable) state_nx = ST_RESET;
      else
         case (state)
            ST_RESET: state_nx = ST_INIT;
            ST_INIT: state_nx = accept && last_com ? ST_IDLE : ST_INIT;
            default: state_nx = !load ? state : any_req ? ST_ACTIVE : ST_IDLE;
         endcase
   end
   // IDLE and ACTIVE share one rule: each load slot carries a granted byte if any lane has one, else IDLE_SYM
   always_comb begin
      data_nx = data_q;
      valid_nx = valid_q;
      lane_nx = lane_q;
      active_nx = active_q;
      idle_nx = idle_q;
      cnt_nx = init_cnt;
      rr_nx = rr_ptr;
      pop_v = '0;
      if (!bus.enable) begin
         data_nx = '0;
         valid_nx = 1'b0;
         lane_nx = '0;
         active_nx = 1'b0;
         idle_nx = 1'b0;
         cnt_nx = '0;
      end else
         case (state)
            ST_RESET: begin
               data_nx = COM_SYM;
               valid_nx = 1'b1;
               lane_nx = '0;
               active_nx = 1'b0;
               idle_nx = 1'b0;
               cnt_nx = '0;
            end
            ST_INIT:
               if (accept) begin
                  cnt_nx = last_com ? '0 : init_cnt + 1'b1;
                  data_nx = last_com ? IDLE_SYM : COM_SYM;
                  idle_nx = last_com;
               end
            default:
               if (load) begin
                  pop_v[grant] = any_req;
                  data_nx = any_req ? head_v[grant] : IDLE_SYM;
                  lane_nx = any_req ? grant : '0;
                  active_nx = any_req;
                  idle_nx = !any_req;
                  valid_nx = 1'b1;
                  rr_nx = any_req ? grant + 1'b1 : rr_ptr;
               end
         endcase
   end
   always_ff @(posedge clk_f or posedge reset) begin
      if (reset) begin
         data_q <= '0;
         valid_q <= 1'b0;
         lane_q <= '0;
         active_q <= 1'b0;
         idle_q <= 1'b0;
         ovf_q <= 1'b0;
         init_cnt <= '0;
         rr_ptr <= '0;
      end else begin
         data_q <= data_nx;
         valid_q <= valid_nx;
         lane_q <= lane_nx;
         active_q <= active_nx;
         idle_q <= idle_nx;
         ovf_q <= ovf_q | (|(valid_v & full_v));
         init_cnt <= cnt_nx;
         rr_ptr <= rr_nx;
      end
   end
   assign bus.data_out = data_q;
   assign bus.valid_out = valid_q;
   assign bus.lane_out = lane_q;
   assign bus.active = active_q;
   assign bus.idle_out = idle_q;
   assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_phy_tx_lane_arbiter.sv
// tb_phy_tx_lane_arbiter: directed checks of bring-up, round-robin merge, stall, overflow, enable and reset
module tb_phy_tx_lane_arbiter;
   logic clk_f = 1'b0;
   logic reset = 1'b1;
   int tests = 0;
   int fails = 0;
   phy_tx_lane_arbiter_if #(.DATA_W(8)) bus ();
   phy_tx_lane_arbiter dut (.clk_f(clk_f), .reset(reset), .bus(bus));
   always #5 clk_f = ~clk_f;

   task automatic tick;
      @(posedge clk_f);
      #1;
   endtask

   task automatic drive(input logic [3:0] v, input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] d3);
      bus.valid0 = v[0];
      bus.valid1 = v[1];
      bus.valid2 = v[2];
      bus.valid3 = v[3];
      bus.data_in0 = d0;
      bus.data_in1 = d1;
      bus.data_in2 = d2;
      bus.data_in3 = d3;
   endtask

   task automatic test_reset;
      bus.enable = 1'b0;
      bus.out_ready = 1'b0;
      drive(4'h0, 8'h0, 8'h0, 8'h0, 8'h0);
      #12;
      tests++;
      if ({bus.data_out, bus.valid_out, bus.lane_out, bus.active, bus.idle_out, bus.overflow} !== 14'h0) begin
         fails++;
         $display("FAIL reset_outputs got data=%h v=%b lane=%0d act=%b idle=%b ovf=%b exp all 0",
                  bus.data_out, bus.valid_out, bus.lane_out, bus.active, bus.idle_out, bus.overflow);
      end
      tests++;
      if ({bus.full3, bus.full2, bus.full1, bus.full0} !== 4'h0) begin
         fails++;
         $display("FAIL reset_full got %b%b%b%b exp 0000", bus.full3, bus.full2, bus.full1, bus.full0);
      end
      reset = 1'b0;
   endtask

   task automatic test_bringup;
      bus.enable = 1'b1;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick;
         tests++;
         if ({bus.valid_out, bus.data_out, bus.idle_out, bus.active} !== {1'b1, 8'hBC, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL bringup_com%0d got v=%b data=%h idle=%b act=%b exp v=1 data=bc idle=0 act=0",
                     k, bus.valid_out, bus.data_out, bus.idle_out, bus.active);
         end
      end
      tick;
      tests++;
      if ({bus.valid_out, bus.data_out, bus.idle_out, bus.active} !== {1'b1, 8'h7C, 1'b1, 1'b0}) begin
         fails++;
         $display("FAIL bringup_idle got v=%b data=%h idle=%b act=%b exp v=1 data=7c idle=1 act=0",
                  bus.valid_out, bus.data_out, bus.idle_out, bus.active);
      end
   endtask

   task automatic test_round_robin;
      drive(4'hF, 8'h10, 8'h20, 8'h30, 8'h40);
      tick;
      drive(4'h0, 8'h0, 8'h0, 8'h0, 8'h0);
      for (int k = 0; k < 4; k++) begin
         tick;
         tests++;
         if ({bus.data_out, bus.lane_out, bus.active, bus.idle_out} !== {8'(8'h10 * (k + 1)), 2'(k), 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL round_robin%0d got data=%h lane=%0d act=%b idle=%b exp data=%h lane=%0d act=1 idle=0",
                     k, bus.data_out, bus.lane_out, bus.active, bus.idle_out, 8'(8'h10 * (k + 1)), k);
         end
      end
      tick;
      tests++;
      if ({bus.data_out, bus.lane_out, bus.active, bus.idle_out} !== {8'h7C, 2'd0, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL round_robin_idle got data=%h lane=%0d act=%b idle=%b exp data=7c lane=0 act=0 idle=1",
                  bus.data_out, bus.lane_out, bus.active, bus.idle_out);
      end
   endtask

   task automatic test_rr_pointer;
      logic [7:0] exp_d [6] = '{8'hB1, 8'hA1, 8'hB2, 8'hA2, 8'hB3, 8'hA3};
      logic [1:0] exp_l [6] = '{2'd3, 2'd1, 2'd3, 2'd1, 2'd3, 2'd1};
      drive(4'b0010, 8'h0, 8'h5A, 8'h0, 8'h0);
      tick;
      drive(4'h0, 8'h0, 8'h0, 8'h0, 8'h0);
      tick;
      tests++;
      if ({bus.data_out, bus.lane_out} !== {8'h5A, 2'd1}) begin
         fails++;
         $display("FAIL rr_setup got data=%h lane=%0d exp data=5a lane=1", bus.data_out, bus.lane_out);
      end
      tick;
      bus.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive(4'b1010, 8'h0, 8'(8'hA1 + k), 8'h0, 8'(8'hB1 + k));
         tick;
      end
      drive(4'h0, 8'h0, 8'h0, 8'h0, 8'h0);
      bus.out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick;
         tests++;
         if ({bus.data_out, bus.lane_out, bus.active} !== {exp_d[k], exp_l[k], 1'b1}) begin
            fails++;
            $display("FAIL rr_order%0d got data=%h lane=%0d act=%b exp data=%h lane=%0d act=1",
                     k, bus.data_out, bus.lane_out, bus.active, exp_d[k], exp_l[k]);
         end
      end
      tick;
      tests++;
      if ({bus.data_out, bus.idle_out} !== {8'h7C, 1'b1}) begin
         fails++;
         $display("FAIL rr_idle got data=%h idle=%b exp data=7c idle=1", bus.data_out, bus.idle_out);
      end
   endtask

   task automatic test_stall_overflow;
      bus.out_ready = 1'b0;
      drive(4'b0100, 8'h0, 8'h0, 8'h55, 8'h0);
      tick;
      drive(4'h0, 8'h0, 8'h0, 8'h0, 8'h0);
      bus.out_ready = 1'b1;
      tick;
      bus.out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         drive(4'b0001, (k < 4) ? 8'(8'h01 + k) : 8'hEE, 8'h0, 8'h0, 8'h0);
         tick;
         tests++;
         if ({bus.valid_out, bus.data_out, bus.lane_out, bus.active, bus.full0, bus.overflow} !==
             {1'b1, 8'h55, 2'd2, 1'b1, k >= 3, k == 4}) begin
            fails++;
            $display("FAIL stall%0d got v=%b data=%h lane=%0d act=%b full0=%b ovf=%b exp v=1 data=55 lane=2 act=1 full0=%b ovf=%b",
                     k, bus.valid_out, bus.data_out, bus.lane_out, bus.active, bus.full0, bus.overflow, k >= 3, k == 4);
         end
      end
      drive(4'h0, 8'h0, 8'h0, 8'h0, 8'h0);
      bus.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick;
         tests++;
         if ({bus.data_out, bus.lane_out, bus.active} !== {8'(8'h01 + k), 2'd0, 1'b1}) begin
            fails++;
            $display("FAIL drain%0d got data=%h lane=%0d act=%b exp data=%h lane=0 act=1",
                     k, bus.data_out, bus.lane_out, bus.active, 8'(8'h01 + k));
         end
      end
      tick;
      tests++;
      if ({bus.data_out, bus.idle_out, bus.full0, bus.overflow} !== {8'h7C, 1'b1, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL drain_idle got data=%h idle=%b full0=%b ovf=%b exp data=7c idle=1 full0=0 ovf=1",
                  bus.data_out, bus.idle_out, bus.full0, bus.overflow);
      end
   endtask

   task automatic test_enable;
      logic got;
      bus.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive(4'b0010, 8'h0, 8'(8'h61 + k), 8'h0, 8'h0);
         tick;
      end
      drive(4'h0, 8'h0, 8'h0, 8'h0, 8'h0);
      bus.out_ready = 1'b1;
      tick;
      tests++;
      if ({bus.data_out, bus.lane_out, bus.active} !== {8'h61, 2'd1, 1'b1}) begin
         fails++;
         $display("FAIL enable_setup got data=%h lane=%0d act=%b exp data=61 lane=1 act=1", bus.data_out, bus.lane_out, bus.active);
      end
      bus.enable = 1'b0;
      tick;
      tests++;
      if ({bus.valid_out, bus.active} !== 2'b00) begin
         fails++;
         $display("FAIL enable_low got v=%b act=%b exp v=0 act=0", bus.valid_out, bus.active);
      end
      tick;
      bus.enable = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick;
         tests++;
         if ({bus.valid_out, bus.data_out} !== {1'b1, 8'hBC}) begin
            fails++;
            $display("FAIL reenable_com%0d got v=%b data=%h exp v=1 data=bc", k, bus.valid_out, bus.data_out);
         end
      end
      got = 1'b0;
      for (int k = 0; k < 4 && !got; k++) begin
         tick;
         if (bus.active) got = 1'b1;
      end
      tests++;
      if ({got, bus.data_out, bus.lane_out} !== {1'b1, 8'h62, 2'd1}) begin
         fails++;
         $display("FAIL reenable_q0 got found=%b data=%h lane=%0d exp found=1 data=62 lane=1", got, bus.data_out, bus.lane_out);
      end
      tick;
      tests++;
      if ({bus.data_out, bus.lane_out, bus.active} !== {8'h63, 2'd1, 1'b1}) begin
         fails++;
         $display("FAIL reenable_q1 got data=%h lane=%0d act=%b exp data=63 lane=1 act=1", bus.data_out, bus.lane_out, bus.active);
      end
      tick;
   endtask

   task automatic test_async_reset;
      bus.enable = 1'b0;
      tick;
      bus.enable = 1'b1;
      tick;
      tick;
      #2 reset = 1'b1;
      #1;
      tests++;
      if ({bus.data_out, bus.valid_out, bus.lane_out, bus.active, bus.idle_out, bus.overflow} !== 14'h0) begin
         fails++;
         $display("FAIL areset_init got data=%h v=%b lane=%0d act=%b idle=%b ovf=%b exp all 0",
                  bus.data_out, bus.valid_out, bus.lane_out, bus.active, bus.idle_out, bus.overflow);
      end
      reset = 1'b0;
      for (int k = 0; k < 5; k++) tick;
      tests++;
      if ({bus.data_out, bus.idle_out} !== {8'h7C, 1'b1}) begin
         fails++;
         $display("FAIL areset_restart got data=%h idle=%b exp data=7c idle=1", bus.data_out, bus.idle_out);
      end
      bus.out_ready = 1'b0;
      drive(4'b1000, 8'h0, 8'h0, 8'h0, 8'hC1);
      tick;
      drive(4'b1000, 8'h0, 8'h0, 8'h0, 8'hC2);
      tick;
      drive(4'h0, 8'h0, 8'h0, 8'h0, 8'h0);
      bus.out_ready = 1'b1;
      tick;
      tests++;
      if ({bus.data_out, bus.lane_out, bus.active} !== {8'hC1, 2'd3, 1'b1}) begin
         fails++;
         $display("FAIL areset_active_setup got data=%h lane=%0d act=%b exp data=c1 lane=3 act=1", bus.data_out, bus.lane_out, bus.active);
      end
      #2 reset = 1'b1;
      #1;
      tests++;
      if ({bus.data_out, bus.valid_out, bus.lane_out, bus.active, bus.idle_out, bus.overflow} !== 14'h0) begin
         fails++;
         $display("FAIL areset_active got data=%h v=%b lane=%0d act=%b idle=%b ovf=%b exp all 0",
                  bus.data_out, bus.valid_out, bus.lane_out, bus.active, bus.idle_out, bus.overflow);
      end
      reset = 1'b0;
      for (int k = 0; k < 8; k++) tick;
      tests++;
      if ({bus.data_out, bus.idle_out, bus.active} !== {8'h7C, 1'b1, 1'b0}) begin
         fails++;
         $display("FAIL areset_fifo_empty got data=%h idle=%b act=%b exp data=7c idle=1 act=0", bus.data_out, bus.idle_out, bus.active);
      end
   endtask

   initial begin
      test_reset;
      test_bringup;
      test_round_robin;
      test_rr_pointer;
      test_stall_overflow;
      test_enable;
      test_async_reset;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
